ddr_frame_writer: RTL and testbench

- Upstream feeder for the system's DDR3 controller Avalon-MM slave port: 16-bit DDR3, half-rate, 64-bit local interface.
- Accepts a pixel/word stream with frame markers and buffers it in an internal FIFO.
- Issues Avalon-MM burst writes into a frame buffer starting at a configurable base address.
- Flushes a partial final burst at end of frame and signals frame completion.

---
 rtl/ddr_frame_writer.sv | 180 ++++++++++++++++++
 tb/tb_ddr_frame_writer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: buffers a framed word stream in a first-word-fall-through
// FIFO and drains it as Avalon-MM burst writes into a frame buffer. A burst
// of BURST_LEN beats is issued whenever that many words are buffered. A
// partial burst is flushed at end of frame, or when a new frame starts
// before the current one has ended.
module ddr_frame_writer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 26,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int BCW        = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic                  st_sop,
  input  logic                  st_eop,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [BCW-1:0]        avm_burstcount,
  input  logic                  avm_waitrequest,
  output logic                  frame_done,
  output logic                  sop_err,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // FIFO storage and pointers
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  // Burst engine state
  state_t            r_state;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [BCW-1:0]    r_bc;
  logic [BCW-1:0]    r_beats;
  logic              r_write;
  logic              r_frame_done;

  // Frame tracking
  logic              r_eop_pending;
  logic              r_addr_valid;
  logic              r_flush;
  logic              r_sop_err;

  logic              w_full;
  logic              w_empty;
  logic              w_busy;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_last_beat;
  logic              w_fd_set;
  logic              w_sop_open;
  logic              w_flush_done;
  logic              w_start;
  logic [BCW-1:0]    w_bc;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_busy   = !w_empty || (r_state != S_IDLE);
  // A sop is held off while anything of the previous frame is still in flight
  assign w_ready  = !w_full && !r_eop_pending && !(st_sop && (w_busy || r_addr_valid));
  assign w_push   = st_valid && w_ready;
  assign w_pop    = r_write && !avm_waitrequest;
  assign w_last_beat = w_pop && (r_beats == BCW'(1));
  // Input is blocked once eop is pending, so one word left means the frame drains now
  assign w_fd_set = w_last_beat && r_eop_pending && (r_count == CW'(1));
  // A sop offered on a frame that never saw its eop aborts that frame
  assign w_sop_open   = st_valid && st_sop && r_addr_valid && !r_eop_pending;
  assign w_flush_done = r_flush && (r_state == S_IDLE) && w_empty;
  assign w_bc    = (r_count >= CW'(BURST_LEN)) ? BCW'(BURST_LEN) : BCW'(r_count);
  assign w_start = (r_state == S_IDLE) &&
                   ((r_count >= CW'(BURST_LEN)) || ((r_flush || r_eop_pending) && !w_empty));

  assign st_ready       = w_ready;
  assign busy           = w_busy;
  assign avm_address    = r_addr;
  assign avm_write      = r_write;
  assign avm_burstcount = r_bc;
  assign avm_writedata  = r_write ? r_mem[r_rptr] : '0;
  assign avm_byteenable = {(DATA_W/8){r_write}};
  assign frame_done     = r_frame_done;
  assign sop_err        = r_sop_err;

  // FIFO data storage (no reset needed, occupancy is tracked by pointers)
  always_ff @(posedge clk_clk) begin
    if (w_push) r_mem[r_wptr] <= st_data;
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Burst FSM: latch address/length on entry, count beats, advance the write pointer
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_bc         <= '0;
      r_beats      <= '0;
      r_next_addr  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_push && st_sop) r_next_addr <= cfg_base_addr;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BURST;
            r_write <= 1'b1;
            r_bc    <= w_bc;
            r_beats <= w_bc;
            r_addr  <= r_next_addr;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_beats <= r_beats - BCW'(1);
            if (w_last_beat) begin
              r_write     <= 1'b0;
              r_state     <= S_IDLE;
              r_next_addr <= r_next_addr + ADDR_W'(r_bc);
              if (w_fd_set) r_frame_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame bookkeeping: open-frame flag, pending eop, abort flush and sticky error
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_eop_pending <= 1'b0;
      r_addr_valid  <= 1'b0;
      r_flush       <= 1'b0;
      r_sop_err     <= 1'b0;
    end else begin
      if (w_push && st_eop)  r_eop_pending <= 1'b1;
      else if (w_fd_set)     r_eop_pending <= 1'b0;

      if (w_push && st_sop)               r_addr_valid <= 1'b1;
      else if (w_fd_set || w_flush_done)  r_addr_valid <= 1'b0;

      if (w_flush_done)    r_flush <= 1'b0;
      else if (w_sop_open) r_flush <= 1'b1;

      if (w_sop_open) r_sop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Testbench for ddr_frame_writer: a frame-level reference model predicts every
// Avalon beat (address, burstcount, data) and each frame_done; a monitor
// checks the DUT's accepted beats against that queue.
module tb_ddr_frame_writer;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 26;
  localparam int BL     = 8;
  localparam int DEPTH  = 32;
  localparam int BCW    = 4;

  logic              clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic              st_sop = 1'b0;
  logic              st_eop = 1'b0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [BCW-1:0]    avm_burstcount;
  logic              avm_waitrequest = 1'b0;
  logic              frame_done;
  logic              sop_err;
  logic              busy;

  ddr_frame_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .BCW(BCW)
  ) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .cfg_base_addr(cfg_base_addr),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .frame_done(frame_done),
    .sop_err(sop_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int err = 0;
  int chk = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BCW-1:0]    bc;
    logic [DATA_W-1:0] data;
    bit                last;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] m_buf[$];
  logic [ADDR_W-1:0] m_next = '0;
  bit                m_open = 1'b0;
  int                fd_exp = 0;
  int                fd_seen = 0;
  int                beats_seen = 0;
  int                acc_count = 0;
  int                acc_cyc_q[$];
  int                wr_mode = 0;
  bit                arm_rise = 1'b0;
  int                rise_cyc = 0;
  bit                prev_write = 1'b0;
  bit                last_beat_flag = 1'b0;
  int                last_beat_cyc = -10;

  // Reference model: bursts are consecutive runs of BL words from the write
  // pointer, with the remainder written at eop or when a new sop aborts a frame.
  function automatic void emit_burst(input bit end_of_frame);
    int n;
    beat_t b;
    n = m_buf.size();
    for (int i = 0; i < n; i++) begin
      b.addr = m_next;
      b.bc   = BCW'(n);
      b.data = m_buf[i];
      b.last = end_of_frame && (i == n - 1);
      exp_q.push_back(b);
    end
    m_next = m_next + ADDR_W'(n);
    m_buf.delete();
  endfunction

  function automatic void model_word(input logic [DATA_W-1:0] d, input bit sop, input bit eop,
                                     input logic [ADDR_W-1:0] base);
    if (sop) begin
      if (m_open && m_buf.size() > 0) emit_burst(1'b0);
      m_next = base;
      m_open = 1'b1;
    end
    m_buf.push_back(d);
    if (m_buf.size() == BL) emit_burst(eop);
    if (eop) begin
      if (m_buf.size() > 0) emit_burst(1'b1);
      fd_exp++;
      m_open = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Waitrequest pattern: 0 = never stall, 1 = always stall, 2 = random
  always @(negedge clk) begin
    case (wr_mode)
      0:       avm_waitrequest = 1'b0;
      1:       avm_waitrequest = 1'b1;
      default: avm_waitrequest = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every accepted beat and every frame_done pulse
  always @(negedge clk) begin
    beat_t e;
    #2;
    if (!reset_reset) begin
      if (avm_write && !avm_waitrequest) begin
        chk++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL unexpected_beat: addr=%0h bc=%0d data=%0h, no beat expected",
                   avm_address, avm_burstcount, avm_writedata);
        end else begin
          e = exp_q.pop_front();
          if (avm_address !== e.addr || avm_burstcount !== e.bc ||
              avm_writedata !== e.data || avm_byteenable !== 8'hFF) begin
            err++;
            $display("FAIL beat: got addr=%0h bc=%0d data=%0h be=%0h expected addr=%0h bc=%0d data=%0h be=ff",
                     avm_address, avm_burstcount, avm_writedata, avm_byteenable, e.addr, e.bc, e.data);
          end
          last_beat_flag = e.last;
          last_beat_cyc  = cyc;
        end
        beats_seen++;
      end
      if (frame_done) begin
        chk++;
        if (!(last_beat_flag && last_beat_cyc == cyc - 1)) begin
          err++;
          $display("FAIL frame_done_timing: got pulse at cycle %0d (last beat cycle %0d, frame end %0d) expected cycle after final frame beat",
                   cyc, last_beat_cyc, last_beat_flag);
        end
        last_beat_flag = 1'b0;
        fd_seen++;
      end
      if (arm_rise && avm_write && !prev_write) begin
        rise_cyc = cyc;
        arm_rise = 1'b0;
      end
    end
    prev_write = avm_write;
  end

  task automatic send_word(input logic [DATA_W-1:0] d, input bit sop, input bit eop,
                           input logic [ADDR_W-1:0] base, input int gap);
    int waited;
    model_word(d, sop, eop, base);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    st_data = d; st_sop = sop; st_eop = eop; cfg_base_addr = base; st_valid = 1'b1;
    waited = 0;
    #1;
    while (!st_ready && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!st_ready) begin
      chk++; err++;
      $display("FAIL stream_accept_timeout: got st_ready=0 for %0d cycles expected 1", waited);
      st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
      return;
    end
    acc_cyc_q.push_back(cyc);
    acc_count++;
    @(posedge clk);
    #1;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [ADDR_W-1:0] base, input bit sop,
                            input bit eop, input bit rnd, input int max_gap);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? {$urandom, $urandom} : DATA_W'(i);
      send_word(d, sop && (i == 0), eop && (i == n - 1), base, $urandom_range(0, max_gap));
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    @(negedge clk); #3;
    while ((exp_q.size() != 0 || busy || avm_write) && t < 5000) begin
      @(negedge clk); #3;
      t++;
    end
    if (t >= 5000) begin
      chk++; err++;
      $display("FAIL %s_drain_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
    #3;
    check({name, "_frame_done_count"}, 64'(fd_seen), 64'(fd_exp));
    check({name, "_ready_idle"}, 64'(st_ready), 64'd1);
  endtask

  initial begin
    int a0;
    int b0;
    #900000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int b0;
    // Power-on reset
    repeat (3) @(negedge clk);
    reset_reset = 1'b0;
    #3;
    check("rst_ready", 64'(st_ready), 64'd1);
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    check("rst_bc", 64'(avm_burstcount), 64'd0);
    check("rst_be", 64'(avm_byteenable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sop_err", 64'(sop_err), 64'd0);

    // 16-word frame at 0x1000 with incrementing data, latency of first write
    arm_rise = 1'b1;
    a0 = acc_count;
    send_frame(16, 26'h1000, 1'b1, 1'b1, 1'b0, 2);
    drain("frame16");
    check("first_write_latency", 64'(rise_cyc - acc_cyc_q[a0 + 7]), 64'd2);

    // 11-word frame: full burst plus 3-beat remainder
    send_frame(11, 26'h2000, 1'b1, 1'b1, 1'b1, 1);
    drain("frame11");

    // 64-word frame under random waitrequest
    wr_mode = 2;
    send_frame(64, 26'h4000, 1'b1, 1'b1, 1'b1, 1);
    drain("frame64_rand_wait");
    wr_mode = 0;

    // Stalled slave: FIFO fills at DEPTH words, then drains on release
    wr_mode = 1;
    a0 = acc_count;
    b0 = beats_seen;
    fork
      send_frame(40, 26'h0, 1'b0, 1'b0, 1'b1, 0);
    join_none
    repeat (100) @(negedge clk);
    #3;
    check("stall_accepted", 64'(acc_count - a0), 64'd32);
    check("stall_ready", 64'(st_ready), 64'd0);
    wr_mode = 0;
    wait fork;
    drain("stall_release");
    check("stall_beats", 64'(beats_seen - b0), 64'd40);

    // sop on an open frame: flush 5 words at old base, then new frame at 0x3000
    send_frame(5, 26'h5000, 1'b1, 1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);
    #3;
    check("sop_err_before", 64'(sop_err), 64'd0);
    send_frame(8, 26'h3000, 1'b1, 1'b1, 1'b1, 0);
    drain("sop_abort");
    check("sop_err_after", 64'(sop_err), 64'd1);

    // Address wrap at the top of the address space
    send_frame(8, 26'h3FFFFFC, 1'b1, 1'b1, 1'b1, 0);
    send_frame(8, 26'h0, 1'b0, 1'b1, 1'b1, 0);
    drain("wrap");

    // Reset mid-burst abandons everything
    wr_mode = 1;
    send_frame(12, 26'h6000, 1'b1, 1'b0, 1'b1, 0);
    @(negedge clk);
    reset_reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete(); m_buf.delete();
    m_next = '0; m_open = 1'b0;
    last_beat_flag = 1'b0;
    reset_reset = 1'b0;
    wr_mode = 0;
    #3;
    check("mid_rst_write", 64'(avm_write), 64'd0);
    check("mid_rst_addr", 64'(avm_address), 64'd0);
    check("mid_rst_bc", 64'(avm_burstcount), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(st_ready), 64'd1);
    check("mid_rst_sop_err", 64'(sop_err), 64'd0);
    b0 = beats_seen;
    repeat (20) @(negedge clk);
    #3;
    check("mid_rst_no_writes", 64'(beats_seen - b0), 64'd0);
    send_frame(3, 26'h10, 1'b1, 1'b1, 1'b1, 0);
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
